// File: rtl/gfx_line_if.sv
// gfx_line_if: command handshake and pixel-stream signals of the line rasterizer
interface gfx_line_if #(
  parameter int XB = 10,
  parameter int YB = 9,
  parameter int PB = 12
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [XB-1:0] cmd_x0;
  logic [YB-1:0] cmd_y0;
  logic [XB-1:0] cmd_x1;
  logic [YB-1:0] cmd_y1;
  logic [PB-1:0] cmd_color;
  logic          pvalid;
  logic          pready;
  logic [XB-1:0] x;
  logic [YB-1:0] y;
  logic [PB-1:0] color;
  logic          last;
  modport master (
    output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, pready,
    input  cmd_ready, pvalid, x, y, color, last
  );
  modport slave (
    input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, pready,
    output cmd_ready, pvalid, x, y, color, last
  );
endinterface

// File: rtl/gfx_line.sv
// gfx_line: Bresenham line rasterizer emitting one pixel per cycle with backpressure
module gfx_line #(
  parameter int FB_WIDTH   = 640,
  parameter int FB_HEIGHT  = 480,
  parameter int PIXEL_BITS = 12
) (
  input logic       clk,
  input logic       reset,
  gfx_line_if.slave bus
);
  localparam int FB_X_BITS = $clog2(FB_WIDTH);
  localparam int FB_Y_BITS = $clog2(FB_HEIGHT);
  localparam int W = (FB_X_BITS > FB_Y_BITS ? FB_X_BITS : FB_Y_BITS) + 2;
  localparam logic [FB_X_BITS-1:0] XMAX = FB_X_BITS'(FB_WIDTH - 1);
  localparam logic [FB_Y_BITS-1:0] YMAX = FB_Y_BITS'(FB_HEIGHT - 1);
  typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;
  state_t                 state_q, state_d;
  logic [FB_X_BITS-1:0]   x0_q, x0_d, x1_q, x1_d, cx_q, cx_d, nx;
  logic [FB_Y_BITS-1:0]   y0_q, y0_d, y1_q, y1_d, cy_q, cy_d, ny;
  logic [PIXEL_BITS-1:0]  color_q, color_d;
  logic signed [W-1:0]    dx_q, dx_d, dy_q, dy_d, err_q, err_d, e2;
  logic                   sx_q, sx_d, sy_q, sy_d, pvalid_q, pvalid_d, last_q, last_d;
  logic                   step_x, step_y;
  assign bus.pvalid = pvalid_q;
  assign bus.x      = cx_q;
  assign bus.y      = cy_q;
  assign bus.color  = color_q;
  assign bus.last   = last_q;
  // next-state: accept and clamp in IDLE, derive deltas in SETUP, walk one Bresenham step per accepted pixel in DRAW
  always_comb begin
    state_d       = state_q;
    x0_d          = x0_q;
    y0_d          = y0_q;
    x1_d          = x1_q;
    y1_d          = y1_q;
    cx_d          = cx_q;
    cy_d          = cy_q;
    color_d       = color_q;
    dx_d          = dx_q;
    dy_d          = dy_q;
    err_d         = err_q;
    sx_d          = sx_q;
    sy_d          = sy_q;
    pvalid_d      = pvalid_q;
    last_d        = last_q;
    bus.cmd_ready = (state_q == IDLE) && !reset;
    e2            = err_q <<< 1;
    step_x        = e2 >= dy_q;
    step_y        = e2 <= dx_q;
    nx            = step_x ? (sx_q ? cx_q - 1'b1 : cx_q + 1'b1) : cx_q;
    ny            = step_y ? (sy_q ? cy_q - 1'b1 : cy_q + 1'b1) : cy_q;
    case (state_q)
      IDLE: if (bus.cmd_valid && bus.cmd_ready) begin
        x0_d    = bus.cmd_x0 > XMAX ? XMAX : bus.cmd_x0;
        y0_d    = bus.cmd_y0 > YMAX ? YMAX : bus.cmd_y0;
        x1_d    = bus.cmd_x1 > XMAX ? XMAX : bus.cmd_x1;
        y1_d    = bus.cmd_y1 > YMAX ? YMAX : bus.cmd_y1;
        color_d = bus.cmd_color;
        state_d = SETUP;
      end
      SETUP: begin
        dx_d     = W'(x1_q > x0_q ? x1_q - x0_q : x0_q - x1_q);
        dy_d     = -W'(y1_q > y0_q ? y1_q - y0_q : y0_q - y1_q);
        sx_d     = x0_q >= x1_q;
        sy_d     = y0_q >= y1_q;
        err_d    = dx_d + dy_d;
        cx_d     = x0_q;
        cy_d     = y0_q;
        pvalid_d = 1'b1;
        last_d   = (x0_q == x1_q) && (y0_q == y1_q);
        state_d  = DRAW;
      end
      DRAW: if (pvalid_q && bus.pready) begin
        if (last_q) begin
          pvalid_d = 1'b0;
          last_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          cx_d   = nx;
          cy_d   = ny;
          err_d  = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
          last_d = (nx == x1_q) && (ny == y1_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset aborts any line in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      x0_q     <= '0;
      y0_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      color_q  <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_q     <= 1'b0;
      sy_q     <= 1'b0;
      pvalid_q <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      color_q  <= color_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      err_q    <= err_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      pvalid_q <= pvalid_d;
      last_q   <= last_d;
    end
  end
endmodule

// File: tb/tb_gfx_line.sv
// tb_gfx_line: vector table, explicit pixel sequences and random lines against a Bresenham reference
module tb_gfx_line;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int n, fx, fy, lx, ly;
  typedef struct {
    int x0, y0, x1, y1, c, mode;
    int n, fx, fy, lx, ly;
  } vec_t;
  vec_t tbl[8];

  gfx_line_if #(.XB(10), .YB(9), .PB(12)) bus ();
  gfx_line dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int xy(input int a, input int b);
    return a * 1024 + b;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input int act, input int exp);
    checks++;
    failures++;
    $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // reference: clamp the endpoints, then trace the ideal Bresenham walk into exp_q
  function automatic void model(input int x0, input int y0, input int x1, input int y1);
    int dx, dy, sx, sy, err, e2, px, py, guard;
    x0 = x0 > 639 ? 639 : x0;
    x1 = x1 > 639 ? 639 : x1;
    y0 = y0 > 479 ? 479 : y0;
    y1 = y1 > 479 ? 479 : y1;
    exp_q.delete();
    dx = x1 > x0 ? x1 - x0 : x0 - x1;
    dy = -(y1 > y0 ? y1 - y0 : y0 - y1);
    sx = x0 < x1 ? 1 : -1;
    sy = y0 < y1 ? 1 : -1;
    err = dx + dy;
    px = x0;
    py = y0;
    guard = 0;
    while (guard < 2000) begin
      exp_q.push_back(xy(px, py));
      if (px == x1 && py == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; px += sx; end
      if (e2 <= dx) begin err += dx; py += sy; end
      guard++;
    end
  endfunction

  // drive one command and consume its pixels against exp_q; mode 0 pready=1, 1 pattern 1,0,0, 2 random
  task automatic run_line(input int x0, input int y0, input int x1, input int y1, input int c, input int mode);
    int cyc, hx, hy, hl;
    logic stalled;
    n = 0; fx = -1; fy = -1; lx = -1; ly = -1;
    stalled = 1'b0; hx = 0; hy = 0; hl = 0;
    @(negedge clk);
    bus.cmd_x0 = 10'(x0);
    bus.cmd_y0 = 9'(y0);
    bus.cmd_x1 = 10'(x1);
    bus.cmd_y1 = 9'(y1);
    bus.cmd_color = 12'(c);
    bus.cmd_valid = 1'b1;
    #1;
    cyc = 0;
    while (!bus.cmd_ready && cyc < 50) begin @(negedge clk); #1; cyc++; end
    chk("cmd_ready_wait", int'(bus.cmd_ready), 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    #1;
    chk("setup_pvalid", int'(bus.pvalid), 0);
    chk("setup_cmd_ready", int'(bus.cmd_ready), 0);
    cyc = 0;
    while (cyc < 5000) begin
      @(negedge clk);
      bus.pready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      #1;
      if (cyc == 0) chk("latency_pvalid", int'(bus.pvalid), 1);
      if (!bus.pvalid) begin fail("pvalid_dropped", 0, 1); break; end
      if (stalled) begin
        chk("stall_x", int'(bus.x), hx);
        chk("stall_y", int'(bus.y), hy);
        chk("stall_last", int'(bus.last), hl);
      end
      if (exp_q.size() == 0) begin fail("extra_pixel", xy(int'(bus.x), int'(bus.y)), -1); break; end
      chk("pix_x", int'(bus.x), exp_q[0] / 1024);
      chk("pix_y", int'(bus.y), exp_q[0] % 1024);
      chk("pix_color", int'(bus.color), c);
      chk("pix_last", int'(bus.last), int'(exp_q.size() == 1));
      if (bus.pready) begin
        if (n == 0) begin fx = int'(bus.x); fy = int'(bus.y); end
        lx = int'(bus.x);
        ly = int'(bus.y);
        n++;
        void'(exp_q.pop_front());
        stalled = 1'b0;
        if (exp_q.size() == 0) break;
      end else begin
        stalled = 1'b1;
        hx = int'(bus.x);
        hy = int'(bus.y);
        hl = int'(bus.last);
      end
      cyc++;
    end
    if (cyc >= 5000) fail("pixel_timeout", cyc, 5000);
    @(negedge clk);
    #1;
    chk("post_pvalid", int'(bus.pvalid), 0);
    chk("post_cmd_ready", int'(bus.cmd_ready), 1);
  endtask

  initial begin
    tbl[0] = '{x0:0,    y0:0,   x1:3,   y1:0,   c:'hF00, mode:0, n:4,   fx:0,   fy:0,   lx:3,   ly:0};
    tbl[1] = '{x0:5,    y0:5,   x1:5,   y1:5,   c:'hABC, mode:0, n:1,   fx:5,   fy:5,   lx:5,   ly:5};
    tbl[2] = '{x0:2,    y0:5,   x1:0,   y1:0,   c:'h0F0, mode:0, n:6,   fx:2,   fy:5,   lx:0,   ly:0};
    tbl[3] = '{x0:0,    y0:0,   x1:3,   y1:3,   c:'h00F, mode:1, n:4,   fx:0,   fy:0,   lx:3,   ly:3};
    tbl[4] = '{x0:700,  y0:10,  x1:700, y1:12,  c:'h123, mode:0, n:3,   fx:639, fy:10,  lx:639, ly:12};
    tbl[5] = '{x0:639,  y0:479, x1:0,   y1:0,   c:'h456, mode:2, n:640, fx:639, fy:479, lx:0,   ly:0};
    tbl[6] = '{x0:1000, y0:500, x1:630, y1:470, c:'h789, mode:1, n:10,  fx:639, fy:479, lx:630, ly:470};
    tbl[7] = '{x0:10,   y0:20,  x1:30,  y1:25,  c:'hFFF, mode:2, n:21,  fx:10,  fy:20,  lx:30,  ly:25};
    bus.cmd_valid = 1'b0;
    bus.cmd_x0 = '0; bus.cmd_y0 = '0; bus.cmd_x1 = '0; bus.cmd_y1 = '0;
    bus.cmd_color = '0;
    bus.pready = 1'b1;
    #1;
    chk("rst_pvalid", int'(bus.pvalid), 0);
    chk("rst_last", int'(bus.last), 0);
    chk("rst_x", int'(bus.x), 0);
    chk("rst_y", int'(bus.y), 0);
    chk("rst_color", int'(bus.color), 0);
    chk("rst_cmd_ready", int'(bus.cmd_ready), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rel_cmd_ready", int'(bus.cmd_ready), 1);

    exp_q = '{xy(0,0), xy(1,0), xy(2,0), xy(3,0)};
    run_line(0, 0, 3, 0, 'hF00, 0);
    exp_q = '{xy(2,5), xy(2,4), xy(1,3), xy(1,2), xy(0,1), xy(0,0)};
    run_line(2, 5, 0, 0, 'h0F0, 0);
    exp_q = '{xy(0,0), xy(1,1), xy(2,2), xy(3,3)};
    run_line(0, 0, 3, 3, 'h00F, 1);
    exp_q = '{xy(639,10), xy(639,11), xy(639,12)};
    run_line(700, 10, 700, 12, 'h123, 0);
    exp_q = '{xy(5,5)};
    run_line(5, 5, 5, 5, 'hABC, 0);

    for (int i = 0; i < 8; i++) begin
      model(tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1);
      run_line(tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1, tbl[i].c, tbl[i].mode);
      chk("tbl_count", n, tbl[i].n);
      chk("tbl_first", xy(fx, fy), xy(tbl[i].fx, tbl[i].fy));
      chk("tbl_last", xy(lx, ly), xy(tbl[i].lx, tbl[i].ly));
    end

    for (int i = 0; i < 25; i++) begin
      int rx0, ry0, rx1, ry1, cx0, cy0, cx1, cy1, adx, ady;
      rx0 = int'($urandom_range(0, 700));
      ry0 = int'($urandom_range(0, 520));
      rx1 = int'($urandom_range(0, 700));
      ry1 = int'($urandom_range(0, 520));
      cx0 = rx0 > 639 ? 639 : rx0;
      cy0 = ry0 > 479 ? 479 : ry0;
      cx1 = rx1 > 639 ? 639 : rx1;
      cy1 = ry1 > 479 ? 479 : ry1;
      adx = cx1 > cx0 ? cx1 - cx0 : cx0 - cx1;
      ady = cy1 > cy0 ? cy1 - cy0 : cy0 - cy1;
      model(rx0, ry0, rx1, ry1);
      run_line(rx0, ry0, rx1, ry1, int'($urandom_range(0, 4095)), 2);
      chk("rnd_count", n, (adx > ady ? adx : ady) + 1);
      chk("rnd_last", xy(lx, ly), xy(cx1, cy1));
    end

    @(negedge clk);
    bus.cmd_x0 = 10'd0; bus.cmd_y0 = 9'd0; bus.cmd_x1 = 10'd9; bus.cmd_y1 = 9'd0;
    bus.cmd_color = 12'h5A5;
    bus.cmd_valid = 1'b1;
    bus.pready = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    #1;
    for (int k = 0; k < 10 && !(bus.pvalid && bus.x == 10'd2); k++) begin @(negedge clk); #1; end
    chk("midrst_reach_x", int'(bus.x), 2);
    reset = 1'b1;
    #1;
    chk("midrst_pvalid", int'(bus.pvalid), 0);
    chk("midrst_x", int'(bus.x), 0);
    chk("midrst_y", int'(bus.y), 0);
    chk("midrst_last", int'(bus.last), 0);
    chk("midrst_cmd_ready", int'(bus.cmd_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_rel_ready", int'(bus.cmd_ready), 1);
    model(1, 1, 2, 1);
    run_line(1, 1, 2, 1, 'h3C3, 0);
    chk("midrst_new_count", n, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
